// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
// Package : lu_pkg
// Purpose : Shared types and helpers for the lu row-store controller.
//           - lu_ctrl_state_e : controller FSM encoding (IDLE/START/RUN/DONE)
//           - LU_SIZE/LU_WIDTH: default matrix dimension and part width
//           - elem_re/elem_im : extract real/imag part of element j of a row
//             (element j is {imag, real} at bits [j*2*W +: 2*W])
// Revision: 1.0 - initial release
// ============================================================================
package lu_pkg;

  localparam int LU_SIZE  = 4;
  localparam int LU_WIDTH = 64;
  localparam int LU_ROW_W = LU_SIZE * 2 * LU_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } lu_ctrl_state_e;

  function automatic logic [LU_WIDTH-1:0] elem_re(input logic [LU_ROW_W-1:0] row,
                                                  input int unsigned         j);
    return row[j*2*LU_WIDTH +: LU_WIDTH];
  endfunction

  function automatic logic [LU_WIDTH-1:0] elem_im(input logic [LU_ROW_W-1:0] row,
                                                  input int unsigned         j);
    return row[j*2*LU_WIDTH + LU_WIDTH +: LU_WIDTH];
  endfunction

endpackage : lu_pkg
`default_nettype wire

// File: rtl/lu_row_ram.sv
`default_nettype none
// ============================================================================
// Module  : lu_row_ram
// Purpose : DEPTH x ROW_W row store, one write port and two registered read
//           ports. A read and a write to the same row in one cycle return the
//           old contents (read-before-write).
// Ports   : clk              clock
//           we/waddr/wdata   write port
//           re_a/raddr_a     read port A request, rdata_a one cycle later
//           re_b/raddr_b     read port B request, rdata_b one cycle later
// Revision: 1.0 - initial release
// ============================================================================
module lu_row_ram #(
  parameter int DEPTH  = 4,
  parameter int ROW_W  = 512,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [ROW_W-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [ROW_W-1:0]  rdata_b
);

  logic [ROW_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; non-blocking reads see pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re_a) begin
      rdata_a <= mem[raddr_a];
    end
    if (re_b) begin
      rdata_b <= mem[raddr_b];
    end
  end

endmodule : lu_row_ram
`default_nettype wire

// File: rtl/lu_row_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lu_row_mem_ctrl
// Purpose : Owns the SIZE-row complex matrix store for the lu engine and
//           sequences one decomposition: host load -> engine start -> engine
//           run -> host unload. The store is granted to the host in IDLE/DONE
//           and to the engine in RUN only.
// Ports   : clk_i/rst_ni                  clock, async active-low reset
//           start_i/flush_i               run request, synchronous abort
//           done_o/start_err_o            DONE level, start-rejected pulse
//           host_wr_*                     host row write handshake
//           host_rd_*                     host row read, data 1 cycle later
//           eng_start_o/eng_busy_i/eng_flush_o  lu engine control
//           eng_rd_addr*/eng_row*         engine row read, data 1 cycle later
//           eng_wr_*                      engine row write-back
//           access_err_o                  sticky, engine access outside RUN
// Option  : LU_ROW_CTRL_PERF_EN adds run_cycles_o[31:0] (START+RUN cycles,
//           saturating) and eng_rd_count_o[15:0] (engine reads in RUN).
// Revision: 1.0 - initial release
// ============================================================================
module lu_row_mem_ctrl
  import lu_pkg::*;
#(
  parameter  int SIZE   = LU_SIZE,
  parameter  int WIDTH  = LU_WIDTH,
  localparam int ROW_W  = SIZE * 2 * WIDTH,
  localparam int ADDR_W = $clog2(SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              flush_i,
  output logic              done_o,
  output logic              start_err_o,
  input  logic              host_wr_valid_i,
  output logic              host_wr_ready_o,
  input  logic [ADDR_W-1:0] host_wr_addr_i,
  input  logic [ROW_W-1:0]  host_wr_row_i,
  input  logic              host_rd_valid_i,
  output logic              host_rd_ready_o,
  input  logic [ADDR_W-1:0] host_rd_addr_i,
  output logic [ROW_W-1:0]  host_rd_row_o,
  output logic              host_rd_row_valid_o,
  output logic              eng_start_o,
  input  logic              eng_busy_i,
  output logic              eng_flush_o,
  input  logic [ADDR_W-1:0] eng_rd_addr_i,
  input  logic              eng_rd_addr_valid_i,
  output logic [ROW_W-1:0]  eng_row_o,
  output logic [ADDR_W-1:0] eng_row_addr_o,
  output logic              eng_row_valid_o,
  input  logic              eng_wr_valid_i,
  input  logic [ADDR_W-1:0] eng_wr_addr_i,
  input  logic [ROW_W-1:0]  eng_wr_row_i,
  output logic              eng_wr_ready_o,
  output logic              access_err_o
`ifdef LU_ROW_CTRL_PERF_EN
  ,
  output logic [31:0]       run_cycles_o,
  output logic [15:0]       eng_rd_count_o
`endif
);

  lu_ctrl_state_e state, next_state;

  logic [SIZE-1:0]   loaded;
  logic              seen_busy;
  logic              all_loaded;
  logic              go_start;
  logic              start_rej;
  logic              host_grant;
  logic              eng_grant;

  logic              host_wr_fire;
  logic              host_rd_fire;
  logic              eng_rd_fire;
  logic              eng_wr_fire;
  logic              eng_access;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ROW_W-1:0]  ram_wdata;
  logic [ROW_W-1:0]  eng_rdata;
  logic [ROW_W-1:0]  host_rdata;

  assign all_loaded = &loaded;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs.
  // In DONE the host ready is 1, so host_wr_valid_i alone marks an accepted
  // write; flush has already been handled ahead of the case.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state      = state;
    start_rej       = 1'b0;
    host_grant      = 1'b0;
    eng_grant       = 1'b0;
    eng_start_o     = 1'b0;
    done_o          = 1'b0;
    if (flush_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (all_loaded) next_state = START;
            else            start_rej  = 1'b1;
          end
        end
        START: begin
          next_state = RUN;
        end
        RUN: begin
          if (seen_busy && !eng_busy_i) next_state = DONE;
        end
        DONE: begin
          if (start_i && all_loaded) begin
            next_state = START;
          end else begin
            start_rej = start_i;
            if (host_wr_valid_i) next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end

    case (state)
      IDLE:    host_grant = 1'b1;
      START:   eng_start_o = 1'b1;
      RUN:     eng_grant  = 1'b1;
      DONE: begin
        host_grant = 1'b1;
        done_o     = 1'b1;
      end
      default: host_grant = 1'b0;
    endcase
  end

  assign go_start        = (next_state == START) && (state != START);
  assign host_wr_ready_o = host_grant;
  assign host_rd_ready_o = host_grant;
  assign eng_wr_ready_o  = eng_grant;

  // Accepted transfers; flush drops everything presented in its cycle.
  assign host_wr_fire = host_wr_valid_i && host_grant && !flush_i;
  assign host_rd_fire = host_rd_valid_i && host_grant && !flush_i;
  assign eng_rd_fire  = eng_rd_addr_valid_i && eng_grant && !flush_i;
  assign eng_wr_fire  = eng_wr_valid_i && eng_grant && !flush_i;
  assign eng_access   = (eng_rd_addr_valid_i || eng_wr_valid_i) && !eng_grant;

  // Write port follows the state grant; host and engine never overlap.
  assign ram_we    = host_wr_fire || eng_wr_fire;
  assign ram_waddr = eng_grant ? eng_wr_addr_i : host_wr_addr_i;
  assign ram_wdata = eng_grant ? eng_wr_row_i  : host_wr_row_i;

  lu_row_ram #(
    .DEPTH  (SIZE),
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re_a    (eng_rd_fire),
    .raddr_a (eng_rd_addr_i),
    .rdata_a (eng_rdata),
    .re_b    (host_rd_fire),
    .raddr_b (host_rd_addr_i),
    .rdata_b (host_rdata)
  );

  // RAM read registers are not reset, so data outputs are qualified by valid.
  assign eng_row_o     = eng_row_valid_o     ? eng_rdata  : '0;
  assign host_rd_row_o = host_rd_row_valid_o ? host_rdata : '0;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loaded              <= '0;
      seen_busy           <= 1'b0;
      start_err_o         <= 1'b0;
      eng_flush_o         <= 1'b0;
      access_err_o        <= 1'b0;
      eng_row_valid_o     <= 1'b0;
      eng_row_addr_o      <= '0;
      host_rd_row_valid_o <= 1'b0;
    end else begin
      start_err_o         <= start_rej;
      eng_flush_o         <= flush_i;
      eng_row_valid_o     <= eng_rd_fire;
      host_rd_row_valid_o <= host_rd_fire;
      if (eng_rd_fire) begin
        eng_row_addr_o <= eng_rd_addr_i;
      end

      // START consumes the bitmap so every run needs a complete reload.
      if (flush_i || state == START) begin
        loaded <= '0;
      end else if (host_wr_fire) begin
        loaded[host_wr_addr_i] <= 1'b1;
      end

      if (flush_i || go_start) begin
        seen_busy <= 1'b0;
      end else if (eng_grant && eng_busy_i) begin
        seen_busy <= 1'b1;
      end

      if (flush_i) begin
        access_err_o <= 1'b0;
      end else if (eng_access) begin
        access_err_o <= 1'b1;
      end
    end
  end

`ifdef LU_ROW_CTRL_PERF_EN
  // Counters restart on entry to START and hold once the run is over.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cycles_o   <= '0;
      eng_rd_count_o <= '0;
    end else if (go_start) begin
      run_cycles_o   <= '0;
      eng_rd_count_o <= '0;
    end else begin
      if ((state == START || state == RUN) && run_cycles_o != '1) begin
        run_cycles_o <= run_cycles_o + 32'd1;
      end
      if (eng_rd_fire && eng_rd_count_o != '1) begin
        eng_rd_count_o <= eng_rd_count_o + 16'd1;
      end
    end
  end
`endif

endmodule : lu_row_mem_ctrl
`default_nettype wire

// File: tb/tb_lu_row_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lu_row_mem_ctrl
// Purpose : Self-checking bench for lu_row_mem_ctrl: a table of per-cycle
//           stimulus/expectation records plus hand-written flush and
//           mid-run reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lu_row_mem_ctrl;

  localparam int SIZE   = 4;
  localparam int WIDTH  = 64;
  localparam int ROW_W  = SIZE * 2 * WIDTH;
  localparam int ADDR_W = $clog2(SIZE);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0, flush_i = 1'b0;
  logic              done_o, start_err_o;
  logic              host_wr_valid_i = 1'b0, host_wr_ready_o;
  logic [ADDR_W-1:0] host_wr_addr_i = '0;
  logic [ROW_W-1:0]  host_wr_row_i = '0;
  logic              host_rd_valid_i = 1'b0, host_rd_ready_o;
  logic [ADDR_W-1:0] host_rd_addr_i = '0;
  logic [ROW_W-1:0]  host_rd_row_o;
  logic              host_rd_row_valid_o;
  logic              eng_start_o, eng_busy_i = 1'b0, eng_flush_o;
  logic [ADDR_W-1:0] eng_rd_addr_i = '0;
  logic              eng_rd_addr_valid_i = 1'b0;
  logic [ROW_W-1:0]  eng_row_o;
  logic [ADDR_W-1:0] eng_row_addr_o;
  logic              eng_row_valid_o;
  logic              eng_wr_valid_i = 1'b0;
  logic [ADDR_W-1:0] eng_wr_addr_i = '0;
  logic [ROW_W-1:0]  eng_wr_row_i = '0;
  logic              eng_wr_ready_o, access_err_o;
`ifdef LU_ROW_CTRL_PERF_EN
  logic [31:0]       run_cycles_o;
  logic [15:0]       eng_rd_count_o;
`endif

  lu_row_mem_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .start_i             (start_i),
    .flush_i             (flush_i),
    .done_o              (done_o),
    .start_err_o         (start_err_o),
    .host_wr_valid_i     (host_wr_valid_i),
    .host_wr_ready_o     (host_wr_ready_o),
    .host_wr_addr_i      (host_wr_addr_i),
    .host_wr_row_i       (host_wr_row_i),
    .host_rd_valid_i     (host_rd_valid_i),
    .host_rd_ready_o     (host_rd_ready_o),
    .host_rd_addr_i      (host_rd_addr_i),
    .host_rd_row_o       (host_rd_row_o),
    .host_rd_row_valid_o (host_rd_row_valid_o),
    .eng_start_o         (eng_start_o),
    .eng_busy_i          (eng_busy_i),
    .eng_flush_o         (eng_flush_o),
    .eng_rd_addr_i       (eng_rd_addr_i),
    .eng_rd_addr_valid_i (eng_rd_addr_valid_i),
    .eng_row_o           (eng_row_o),
    .eng_row_addr_o      (eng_row_addr_o),
    .eng_row_valid_o     (eng_row_valid_o),
    .eng_wr_valid_i      (eng_wr_valid_i),
    .eng_wr_addr_i       (eng_wr_addr_i),
    .eng_wr_row_i        (eng_wr_row_i),
    .eng_wr_ready_o      (eng_wr_ready_o),
    .access_err_o        (access_err_o)
`ifdef LU_ROW_CTRL_PERF_EN
    ,
    .run_cycles_o        (run_cycles_o),
    .eng_rd_count_o      (eng_rd_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Row k: element j = {imag, real} with distinct tags; k==10 is all 0xA5.
  function automatic logic [ROW_W-1:0] pat(input int k);
    logic [ROW_W-1:0] r;
    r = '0;
    if (k == 10) begin
      r = {(ROW_W/8){8'hA5}};
    end else begin
      for (int j = 0; j < SIZE; j++) begin
        r[j*2*WIDTH +: WIDTH]         = {32'hC0DE0000, 32'(k*256 + j*2)};
        r[j*2*WIDTH + WIDTH +: WIDTH] = {32'hBEEF0000, 32'(k*256 + j*2 + 1)};
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_row(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start_i = 1'b0; flush_i = 1'b0; host_wr_valid_i = 1'b0; host_rd_valid_i = 1'b0;
    eng_rd_addr_valid_i = 1'b0; eng_wr_valid_i = 1'b0; eng_busy_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the rows are written.
  task automatic load_all();
    for (int r = 0; r < SIZE; r++) begin
      host_wr_valid_i = 1'b1;
      host_wr_addr_i  = ADDR_W'(r);
      host_wr_row_i   = pat(r);
      @(negedge clk_i);
    end
    host_wr_valid_i = 1'b0;
  endtask

  typedef struct {
    logic start, flush, hwv; int hwa, hwk;
    logic hrv; int hra;
    logic erv; int era;
    logic ewv; int ewa, ewk;
    logic busy;
    logic x_done, x_serr, x_estart, x_hrdy, x_ewr, x_erv; int x_eaddr, x_erow;
    logic x_hrv; int x_hrow;
    logic x_aerr, x_eflush;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    //          st fl hwv hwa hwk hrv hra erv era ewv ewa ewk bsy | dn se es hr ew ev ea er hv hw ae ef
    vecs[0]  = '{0, 0, 1, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // wr row0
    vecs[1]  = '{0, 0, 1, 1, 1,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // wr row1
    vecs[2]  = '{0, 0, 1, 3, 3,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // wr row3
    vecs[3]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // start, row2 missing
    vecs[4]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // err pulse ends
    vecs[5]  = '{0, 0, 1, 2, 2,  1, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0}; // wr row2 + rd row0
    vecs[6]  = '{1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // start -> START
    vecs[7]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}; // -> RUN
    vecs[8]  = '{0, 0, 0, 0, 0,  0, 0,  1, 2,  0, 0, 0,  0,  0, 0, 0, 0, 1, 1, 2, 2, 0, 0, 0, 0}; // eng rd row2
    vecs[9]  = '{0, 0, 0, 0, 0,  0, 0,  1, 1,  1, 1, 5,  1,  0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0}; // rd+wr row1: old
    vecs[10] = '{0, 0, 0, 0, 0,  0, 0,  1, 1,  0, 0, 0,  1,  0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0, 0}; // rd row1: new
    vecs[11] = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  1, 2, 10, 1,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}; // eng wr row2 A5
    vecs[12] = '{0, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0}; // busy drop -> DONE
    vecs[13] = '{0, 0, 0, 0, 0,  1, 2,  0, 0,  0, 0, 0,  0,  1, 0, 0, 1, 0, 0, 0, 0, 1, 10, 0, 0}; // host rd row2
    vecs[14] = '{0, 0, 0, 0, 0,  0, 0,  1, 0,  0, 0, 0,  0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0}; // eng rd in DONE
    vecs[15] = '{1, 0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0}; // start, bitmap empty
    vecs[16] = '{0, 0, 1, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0}; // wr in DONE -> IDLE
    vecs[17] = '{0, 1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1}; // flush

    // ---------------- reset state ----------------
    #23;
    chk("rst_done",   done_o,          1'b0);
    chk("rst_wrrdy",  host_wr_ready_o, 1'b1);
    chk("rst_rdrdy",  host_rd_ready_o, 1'b1);
    chk("rst_estart", eng_start_o,     1'b0);
    chk("rst_ewrrdy", eng_wr_ready_o,  1'b0);
    chk("rst_erv",    eng_row_valid_o, 1'b0);
    chk("rst_aerr",   access_err_o,    1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      start_i             = vecs[i].start;
      flush_i             = vecs[i].flush;
      host_wr_valid_i     = vecs[i].hwv;
      host_wr_addr_i      = ADDR_W'(vecs[i].hwa);
      host_wr_row_i       = pat(vecs[i].hwk);
      host_rd_valid_i     = vecs[i].hrv;
      host_rd_addr_i      = ADDR_W'(vecs[i].hra);
      eng_rd_addr_valid_i = vecs[i].erv;
      eng_rd_addr_i       = ADDR_W'(vecs[i].era);
      eng_wr_valid_i      = vecs[i].ewv;
      eng_wr_addr_i       = ADDR_W'(vecs[i].ewa);
      eng_wr_row_i        = pat(vecs[i].ewk);
      eng_busy_i          = vecs[i].busy;
      @(negedge clk_i);
      chk($sformatf("v%0d_done", i),   done_o,              vecs[i].x_done);
      chk($sformatf("v%0d_serr", i),   start_err_o,         vecs[i].x_serr);
      chk($sformatf("v%0d_estart", i), eng_start_o,         vecs[i].x_estart);
      chk($sformatf("v%0d_wrrdy", i),  host_wr_ready_o,     vecs[i].x_hrdy);
      chk($sformatf("v%0d_rdrdy", i),  host_rd_ready_o,     vecs[i].x_hrdy);
      chk($sformatf("v%0d_ewrrdy", i), eng_wr_ready_o,      vecs[i].x_ewr);
      chk($sformatf("v%0d_erv", i),    eng_row_valid_o,     vecs[i].x_erv);
      chk($sformatf("v%0d_hrv", i),    host_rd_row_valid_o, vecs[i].x_hrv);
      chk($sformatf("v%0d_aerr", i),   access_err_o,        vecs[i].x_aerr);
      chk($sformatf("v%0d_eflush", i), eng_flush_o,         vecs[i].x_eflush);
      if (vecs[i].x_erv) begin
        chk($sformatf("v%0d_eaddr", i), 64'(eng_row_addr_o), 64'(vecs[i].x_eaddr));
        chk_row($sformatf("v%0d_erow", i), eng_row_o, pat(vecs[i].x_erow));
      end
      if (vecs[i].x_hrv) begin
        chk_row($sformatf("v%0d_hrow", i), host_rd_row_o, pat(vecs[i].x_hrow));
      end
    end
    clear_inputs();
`ifdef LU_ROW_CTRL_PERF_EN
    // One START cycle plus five RUN cycles; three engine reads.
    chk("perf_run_cycles", 64'(run_cycles_o),   64'd6);
    chk("perf_rd_count",   64'(eng_rd_count_o), 64'd3);
`endif

    // ---------------- flush beats start, flush mid-RUN ----------------
    @(negedge clk_i);
    load_all();
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    chk("fs_estart", eng_start_o, 1'b0);
    chk("fs_eflush", eng_flush_o, 1'b1);
    flush_i = 1'b0;                       // bitmap was cleared by the flush
    @(negedge clk_i);
    chk("fs_serr",    start_err_o, 1'b1);
    chk("fs_estart2", eng_start_o, 1'b0);
    start_i = 1'b0;
    load_all();
    start_i = 1'b1;
    @(negedge clk_i);
    chk("fr_estart", eng_start_o, 1'b1);
    start_i = 1'b0; eng_busy_i = 1'b1;
    @(negedge clk_i);
    chk("fr_run", eng_wr_ready_o, 1'b1);
    flush_i = 1'b1; eng_rd_addr_valid_i = 1'b1; eng_rd_addr_i = 2'd0;
    @(negedge clk_i);
    chk("fr_eflush", eng_flush_o,     1'b1);
    chk("fr_erv",    eng_row_valid_o, 1'b0);
    chk("fr_wrrdy",  host_wr_ready_o, 1'b1);
    chk("fr_ewrrdy", eng_wr_ready_o,  1'b0);
    chk("fr_done",   done_o,          1'b0);
    clear_inputs();
    @(negedge clk_i);
    chk("fr_eflush_end", eng_flush_o, 1'b0);
    start_i = 1'b1;
    @(negedge clk_i);
    chk("fr_serr",   start_err_o, 1'b1);
    chk("fr_nostart", eng_start_o, 1'b0);
    start_i = 1'b0;

    // ---------------- async reset mid-RUN ----------------
    @(negedge clk_i);
    load_all();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; eng_busy_i = 1'b1;
    @(negedge clk_i);
    eng_rd_addr_valid_i = 1'b1; eng_rd_addr_i = 2'd3;
    @(posedge clk_i);
    #2;
    chk("rr_erv_pre", eng_row_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("rr_erv",    eng_row_valid_o, 1'b0);
    chk_row("rr_erow", eng_row_o, '0);
    chk("rr_eaddr",  64'(eng_row_addr_o), 64'd0);
    chk("rr_ewrrdy", eng_wr_ready_o,  1'b0);
    chk("rr_wrrdy",  host_wr_ready_o, 1'b1);
    chk("rr_rdrdy",  host_rd_ready_o, 1'b1);
    chk("rr_done",   done_o,          1'b0);
`ifdef LU_ROW_CTRL_PERF_EN
    chk("rr_run_cycles", 64'(run_cycles_o), 64'd0);
`endif
    clear_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;                       // bitmap cleared by reset
    @(negedge clk_i);
    chk("rr_serr", start_err_o, 1'b1);
    start_i = 1'b0;
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lu_row_mem_ctrl
`default_nettype wire

// File: doc/lu_row_mem_ctrl.md
Name: lu_row_mem_ctrl

Overview:
- Owns the SIZE-row complex matrix row store for the `lu` engine and sequences one decomposition: host load, engine start, engine run, host unload.
- Grants the row store to the host or the engine according to its FSM state, so the two never share it in the same phase.
- Serves engine row reads with the fixed 1-cycle latency that `lu` expects and accepts its write-backs.
- Sits between the host/DMA interface and the `lu` datapath.

Parameters:
- SIZE, 4, matrix dimension (rows = columns).
- WIDTH, 64, bits per real or imaginary part (IEEE double).
- ROW_W, derived = SIZE*2*WIDTH, row width; element j is {imag, real} at bits [j*2*WIDTH +: 2*WIDTH].
- ADDR_W, derived = $clog2(SIZE).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  host request to run one decomposition
- flush_i  in  1  synchronous abort to IDLE
- done_o  out  1  level, high in DONE
- start_err_o  out  1  1-cycle pulse, start rejected
- host_wr_valid_i / host_wr_ready_o  in/out  1/1  host row write handshake
- host_wr_addr_i  in  ADDR_W  host write row
- host_wr_row_i  in  ROW_W  host write data
- host_rd_valid_i / host_rd_ready_o  in/out  1/1  host row read handshake
- host_rd_addr_i  in  ADDR_W  host read row
- host_rd_row_o / host_rd_row_valid_o  out  ROW_W/1  host read data, 1 cycle after accept
- eng_start_o  out  1  1-cycle pulse to lu.start
- eng_busy_i  in  1  from lu.busy_o
- eng_flush_o  out  1  to lu.flush_i
- eng_rd_addr_i / eng_rd_addr_valid_i  in  ADDR_W/1  from lu.mat_row_read_addr_o / lu.mat_row_read_addr_valid_o
- eng_row_o / eng_row_addr_o / eng_row_valid_o  out  ROW_W/ADDR_W/1  to lu.mat_row_i / lu.mat_row_read_addr_i / lu.mat_row_valid_i
- eng_wr_valid_i / eng_wr_addr_i / eng_wr_row_i  in  1/ADDR_W/ROW_W  from lu mat_row write port
- eng_wr_ready_o  out  1  to lu.mat_row_out_ready_i
- access_err_o  out  1  sticky, engine access outside RUN

Behaviour:
- Reset (async, rst_ni=0):
  - State is IDLE and the loaded bitmap is cleared.
  - Every output is 0, except host_wr_ready_o=1 and host_rd_ready_o=1.
  - Row store contents are not reset.
- FSM states: IDLE, START, RUN, DONE.
- IDLE:
  - Host reads and writes are accepted (both readies = 1).
  - Each accepted host write sets loaded[addr].
  - start_i with all loaded bits set moves to START.
  - start_i with any loaded bit clear stays in IDLE and pulses start_err_o.
- START (exactly 1 cycle):
  - eng_start_o=1; host readies are 0.
  - Clears loaded, so the next run requires a full reload.
  - Moves to RUN.
- RUN:
  - Host readies are 0 and eng_wr_ready_o=1.
  - A seen_busy flag is set on the first eng_busy_i=1.
  - eng_busy_i=0 while seen_busy=1 moves to DONE. No timeout.
- DONE:
  - done_o=1; host readies are 1 and host writes set loaded bits again.
  - start_i with a full bitmap goes to START; otherwise it pulses start_err_o.
  - Any accepted host write also returns the FSM to IDLE.
- Engine read path:
  - On an eng_rd_addr_valid_i cycle, the next cycle drives eng_row_o=mem[addr], eng_row_addr_o=addr, eng_row_valid_o=1.
  - Back-to-back reads are sustained at 1 per cycle.
- Host read path: same 1-cycle latency on host_rd_row_o / host_rd_row_valid_o.
- Same-cycle write and read to the same row return the old data (read-before-write).
- Simultaneous host write and host read are both accepted.
- An engine access outside RUN is ignored: no read response, no write. It sets access_err_o, which is cleared only by reset or flush_i.
- flush_i, from any state:
  - Next state is IDLE; loaded and access_err_o are cleared.
  - eng_flush_o pulses for 1 cycle; responses in flight are dropped.
  - flush_i has priority over start_i in the same cycle.
- Asserting reset mid-RUN behaves identically to power-on reset.

Optional Feature:
- Macro: LU_ROW_CTRL_PERF_EN.
- Defined:
  - Adds output run_cycles_o [31:0], counting cycles spent in START+RUN and saturating at 2^32-1.
  - The count is cleared on entry to START and held through DONE/IDLE.
  - Also adds eng_rd_count_o [15:0], counting engine reads accepted in RUN.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package lu_pkg:
  - typedef lu_ctrl_state_e (IDLE, START, RUN, DONE).
  - Functions elem_re() and elem_im() for field extraction.
  - Default constants for SIZE and WIDTH.
- Sub-module lu_row_ram: SIZE x ROW_W, 2 read ports plus 1 write port, registered reads, read-before-write. The controller muxes the write port by state.

Test Plan:
- Load rows 0..3 via host, pulse start_i → eng_start_o pulses exactly 1 cycle later; state reaches RUN.
- Load rows 0,1,3 only, then start_i → start_err_o pulses 1 cycle; eng_start_o stays 0.
- In RUN, issue eng read of addr 2 → next cycle eng_row_o equals host-written row 2 and eng_row_addr_o=2. Then engine writes row 2 with 0xA5…; a host read in DONE returns 0xA5….
- Engine reads addr 1 and writes addr 1 in the same cycle → read returns the old value; a following read returns the new value.
- Assert flush_i mid-RUN → eng_flush_o pulses; state is IDLE; host_wr_ready_o=1; a later start_i without reload → start_err_o.
- Drop rst_ni mid-RUN → all outputs reset asynchronously; with PERF_EN, run_cycles_o=0.
